// File: rtl/sr_drive_sequencer.sv
// rtl/sr_drive_sequencer.sv - Sequences set/reset/hold/toggle requests into legal timed s/r pulses
// and checks the SR flop's q readback after each command.
module sr_drive_sequencer #(
  parameter int PULSE_CYCLES = 2,
  parameter int GAP_CYCLES   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic       q_fb,
  output logic       s,
  output logic       r,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       err_sticky
);

  localparam int MAXC = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_GAP   = 2'd2,
    ST_CHECK = 2'd3
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_exp;
  logic          r_set;
  logic          r_s_drv;
  logic          r_r_drv;
  logic          r_err_sticky;

  state_t        w_next;
  logic [CW-1:0] w_cnt_next;
  logic          w_exp_next;
  logic          w_set_next;
  logic          w_done;
  logic          w_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_exp        <= 1'b0;
      r_set        <= 1'b0;
      r_s_drv      <= 1'b0;
      r_r_drv      <= 1'b0;
      r_err_sticky <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_cnt        <= w_cnt_next;
      r_exp        <= w_exp_next;
      r_set        <= w_set_next;
      // s/r are registered decodes of the next state, so both can only be high inside DRIVE
      r_s_drv      <= (w_next == ST_DRIVE) && w_set_next;
      r_r_drv      <= (w_next == ST_DRIVE) && !w_set_next;
      r_err_sticky <= r_err_sticky | w_err;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_exp_next = r_exp;
    w_set_next = r_set;
    w_done     = 1'b0;
    w_err      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_cnt_next = CW'(PULSE_CYCLES - 1);
          w_next     = ST_DRIVE;
          case (req_op)
            2'b00: begin
              w_exp_next = q_fb;
              w_next     = ST_CHECK;
            end
            2'b01: begin
              w_exp_next = 1'b0;
              w_set_next = 1'b0;
            end
            2'b10: begin
              w_exp_next = 1'b1;
              w_set_next = 1'b1;
            end
            default: begin
              w_exp_next = ~q_fb;
              w_set_next = ~q_fb;
            end
          endcase
        end
      end
      ST_DRIVE: begin
        if (r_cnt == '0) begin
          if (GAP_CYCLES > 0) begin
            w_next     = ST_GAP;
            w_cnt_next = CW'(GAP_CYCLES - 1);
          end else begin
            w_next = ST_CHECK;
          end
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      ST_GAP: begin
        if (r_cnt == '0) begin
          w_next = ST_CHECK;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      default: begin
        w_done = 1'b1;
        w_err  = (q_fb != r_exp);
        w_next = ST_IDLE;
      end
    endcase
  end

  assign req_ready  = (r_state == ST_IDLE);
  assign busy       = (r_state != ST_IDLE);
  assign s          = r_s_drv;
  assign r          = r_r_drv;
  assign done       = w_done;
  assign err        = w_err;
  assign err_sticky = r_err_sticky;

endmodule

// File: tb/tb_sr_drive_sequencer.sv
// tb/tb_sr_drive_sequencer.sv - Directed self-checking bench for sr_drive_sequencer
// with a behavioural SR flop model closing the q feedback loop.
module tb_sr_drive_sequencer;

  localparam int P = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_op = 2'b00;
  logic       q_fb;
  logic       s;
  logic       r;
  logic       busy;
  logic       done;
  logic       err;
  logic       err_sticky;

  logic q_model = 1'b0;
  logic stuck   = 1'b0;
  logic sr_seen = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  sr_drive_sequencer #(.PULSE_CYCLES(2), .GAP_CYCLES(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .q_fb      (q_fb),
    .s         (s),
    .r         (r),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (s && !stuck) q_model <= 1'b1;
    else if (r)      q_model <= 1'b0;
  end
  assign q_fb = q_model;

  always @* begin
    if (s && r) sr_seen = 1'b1;
  end

  task automatic chk(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, expv);
    end
  endtask

  // Called at #1 after an edge; checks every cycle from acceptance to return to IDLE.
  task automatic run_cmd(input string tag, input logic [1:0] op, input logic exp_s,
                         input logic exp_r, input logic exp_err, input logic exp_q);
    int lat;
    lat = (op == 2'b00) ? 1 : 1 + P + 1;
    chk({tag, "_ready"}, req_ready, 1'b1);
    req_valid = 1'b1;
    req_op    = op;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_op    = ~op;
    for (int k = 1; k <= lat; k++) begin
      chk($sformatf("%s_s_c%0d", tag, k), s, exp_s && (k <= P) && (op != 2'b00));
      chk($sformatf("%s_r_c%0d", tag, k), r, exp_r && (k <= P) && (op != 2'b00));
      chk($sformatf("%s_done_c%0d", tag, k), done, k == lat);
      chk($sformatf("%s_err_c%0d", tag, k), err, exp_err && (k == lat));
      chk($sformatf("%s_busy_c%0d", tag, k), busy, 1'b1);
      if (k == lat) chk({tag, "_q"}, q_fb, exp_q);
      @(posedge clk); #1;
    end
    chk({tag, "_idle_ready"}, req_ready, 1'b1);
    chk({tag, "_idle_done"}, done, 1'b0);
  endtask

  initial begin
    @(posedge clk); #1;
    chk("rst_s", s, 1'b0);
    chk("rst_r", r, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_sticky", err_sticky, 1'b0);
    chk("rst_busy", busy, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rel_ready", req_ready, 1'b1);
    @(posedge clk); #1;

    run_cmd("set", 2'b10, 1'b1, 1'b0, 1'b0, 1'b1);
    run_cmd("hold1", 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    run_cmd("reset", 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
    run_cmd("tog1", 2'b11, 1'b1, 1'b0, 1'b0, 1'b1);
    run_cmd("tog2", 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("sticky_clean", err_sticky, 1'b0);

    stuck = 1'b1;
    run_cmd("stuck", 2'b10, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("sticky_set", err_sticky, 1'b1);
    run_cmd("hold0", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("sticky_hold", err_sticky, 1'b1);
    rst = 1'b1;
    #1;
    chk("sticky_clr", err_sticky, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    stuck = 1'b0;
    @(posedge clk); #1;

    req_valid = 1'b1;
    req_op    = 2'b10;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("abort_s_c1", s, 1'b1);
    @(posedge clk); #1;
    chk("abort_s_c2", s, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("abort_s_async", s, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_ready", req_ready, 1'b1);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("abort_nodone_%0d", k), done, 1'b0);
      chk($sformatf("abort_nos_%0d", k), s, 1'b0);
      @(posedge clk); #1;
    end

    chk("never_s_and_r", sr_seen, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
